// File: rtl/pattern_sequencer.sv
// pattern_sequencer: selects the test-pattern code and video timing for an
// external pattern generator. A resolution change is applied only at a frame
// boundary, then the generator is held in reset and re-synchronised. Button
// presses (and, optionally, an auto-cycle timer) advance the pattern code on
// frame boundaries.
// Optional feature: define PATSEQ_AUTO_EN to compile in auto-cycling of
// patterns driven by I_auto and a per-pattern frame counter.
module pattern_sequencer #(
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int NUM_MODES          = 4,
  parameter int RST_CYCLES         = 16
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_vs,
  input  logic        I_btn,
  input  logic        I_auto,
  input  logic [1:0]  I_res_sel,
  output logic [2:0]  O_mode,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol,
  output logic        O_tp_rst_n,
  output logic        O_busy
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        pol;
  } timing_t;

  // Resolution preset table; one polarity bit drives both HS and VS.
  function automatic timing_t preset_lookup(input logic [1:0] sel);
    timing_t t;
    case (sel)
      2'd0:    t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0};
      2'd1:    t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1};
      2'd2:    t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1};
      2'd3:    t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0};
      default: t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0};
    endcase
    return t;
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  rst_cnt_r;
  logic        vs_r;
  logic        vs_d_r;
  timing_t     timing_r;
  logic [1:0]  cur_sel_r;
  logic [2:0]  mode_r;
  logic        pend_r;
  logic        busy_r;
  logic        tp_rst_n_r;
  logic        busy_nxt_s;
  logic        tp_rst_n_nxt_s;
  logic        fb_s;
  logic        expiry_s;
  logic        adv_s;
  logic [2:0]  mode_next_s;

  // Frame boundary: registered VS has just become active under the current polarity.
  assign fb_s = (vs_r == timing_r.pol) && (vs_d_r != timing_r.pol);

  // An advance happens only on a frame boundary while running normally.
  assign adv_s = (state_r == ST_RUN) && fb_s && (pend_r || expiry_s);

  assign mode_next_s = (mode_r == 3'(NUM_MODES - 1)) ? 3'd0 : (mode_r + 3'd1);

`ifdef PATSEQ_AUTO_EN
  logic [7:0] frame_cnt_r;

  assign expiry_s = I_auto && (frame_cnt_r == 8'(FRAMES_PER_PATTERN - 1));

  // Frames shown with the current pattern; held at zero when auto-cycling is off.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if ((state_r != ST_RUN) || !I_auto) begin
      frame_cnt_r <= 8'd0;
    end else if (fb_s) begin
      frame_cnt_r <= adv_s ? 8'd0 : (frame_cnt_r + 8'd1);
    end
  end
`else
  // Auto-cycle is not built; I_auto has no effect on the pattern code.
  assign expiry_s = I_auto & 1'b0;
`endif

  // Register the generator's VS and keep the previous sample for edge detection.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      vs_r   <= 1'b1;
      vs_d_r <= 1'b1;
    end else begin
      vs_r   <= I_vs;
      vs_d_r <= vs_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Length of the generator reset pulse, counted while in RESET.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      rst_cnt_r <= 8'd0;
    end else if (state_r != ST_RESET) begin
      rst_cnt_r <= 8'd0;
    end else begin
      rst_cnt_r <= rst_cnt_r + 8'd1;
    end
  end

  // Next-state decision for the resolution-change sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (I_res_sel != cur_sel_r) next_state_s = ST_DRAIN;
        else                        next_state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (fb_s) next_state_s = ST_RESET;
        else      next_state_s = ST_DRAIN;
      end
      ST_RESET: begin
        if (rst_cnt_r == 8'(RST_CYCLES - 1)) next_state_s = ST_RESYNC;
        else                                 next_state_s = ST_RESET;
      end
      ST_RESYNC: begin
        if (fb_s) next_state_s = ST_RUN;
        else      next_state_s = ST_RESYNC;
      end
      default: next_state_s = ST_RUN;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs align with state_r.
  always_comb begin
    busy_nxt_s     = 1'b0;
    tp_rst_n_nxt_s = 1'b1;
    case (next_state_s)
      ST_RUN: begin
        busy_nxt_s     = 1'b0;
        tp_rst_n_nxt_s = 1'b1;
      end
      ST_RESET: begin
        busy_nxt_s     = 1'b1;
        tp_rst_n_nxt_s = 1'b0;
      end
      ST_DRAIN, ST_RESYNC: begin
        busy_nxt_s     = 1'b1;
        tp_rst_n_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s     = 1'b0;
        tp_rst_n_nxt_s = 1'b1;
      end
    endcase
  end

  // Registered status and generator reset outputs; generator stays in reset while we do.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      busy_r     <= 1'b0;
      tp_rst_n_r <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      tp_rst_n_r <= tp_rst_n_nxt_s;
    end
  end

  // Pending button request; only accepted while running, dropped otherwise.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      pend_r <= 1'b0;
    end else if (state_r != ST_RUN) begin
      pend_r <= 1'b0;
    end else if (adv_s) begin
      pend_r <= I_btn;
    end else if (I_btn) begin
      pend_r <= 1'b1;
    end
  end

  // Timing preset load at the draining frame boundary, and pattern code advance.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      timing_r  <= preset_lookup(2'd0);
      cur_sel_r <= 2'd0;
      mode_r    <= 3'd0;
    end else if ((state_r == ST_DRAIN) && fb_s) begin
      timing_r  <= preset_lookup(I_res_sel);
      cur_sel_r <= I_res_sel;
      mode_r    <= 3'd0;
    end else if (adv_s) begin
      mode_r    <= mode_next_s;
    end
  end

  assign O_mode     = mode_r;
  assign O_h_total  = timing_r.h_total;
  assign O_h_sync   = timing_r.h_sync;
  assign O_h_bporch = timing_r.h_bporch;
  assign O_h_res    = timing_r.h_res;
  assign O_v_total  = timing_r.v_total;
  assign O_v_sync   = timing_r.v_sync;
  assign O_v_bporch = timing_r.v_bporch;
  assign O_v_res    = timing_r.v_res;
  assign O_hs_pol   = timing_r.pol;
  assign O_vs_pol   = timing_r.pol;
  assign O_tp_rst_n = tp_rst_n_r;
  assign O_busy     = busy_r;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter FRAMES_PER_PATTERN, default 60: frame boundaries per pattern in auto-cycle mode; legal range 1..255.
REQ-002 Parameter NUM_MODES, default 4: number of pattern codes cycled, 0..NUM_MODES-1; legal range 1..8.
REQ-003 Parameter RST_CYCLES, default 16: length in cycles of the generator reset pulse; legal range 2..255.
REQ-004 I_pxl_clk  in  1  pixel clock; sole clock.
REQ-005 I_rst_n  in  1  synchronous, active-low reset.
REQ-006 I_vs  in  1  VS output from the pattern generator; polarity set by current O_vs_pol.
REQ-007 I_btn  in  1  single-cycle, debounced next-pattern request.
REQ-008 I_auto  in  1  level; 1 = auto-cycle patterns.
REQ-009 I_res_sel  in  2  requested resolution preset.
REQ-010 O_mode  out  3  pattern code to the generator.
REQ-011 O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res  out  12 each  timing to the generator.
REQ-012 O_hs_pol, O_vs_pol  out  1 each  sync polarity, 1 = active-high.
REQ-013 O_tp_rst_n  out  1  active-low reset to the generator.
REQ-014 O_busy  out  1  high in any state other than RUN.

Function
REQ-015 Presets (h_total/h_sync/h_bporch/h_res, v_total/v_sync/v_bporch/v_res, pol): 0 = 800/96/48/640, 525/2/33/480, 0; 1 = 1056/128/88/800, 628/4/23/600, 1; 2 = 1650/40/220/1280, 750/5/20/720, 1; 3 = 1344/136/160/1024, 806/6/29/768, 0 (pol applies to both HS and VS).
REQ-016 Frame boundary pulse (fb): I_vs registered once; fb=1 the cycle after the registered sample changes from sync-inactive to sync-active, judged with current O_vs_pol.
REQ-017 FSM states: RUN, DRAIN, RESET, RESYNC.
REQ-018 RUN: I_res_sel != current preset -> DRAIN next cycle.
REQ-019 DRAIN: on fb, load all timing outputs from the I_res_sel preset sampled that cycle, clear O_mode to 0, -> RESET.
REQ-020 RESET: O_tp_rst_n=0 for exactly RST_CYCLES cycles, then 1 -> RESYNC.
REQ-021 RESYNC: fb ignored for counting; the first fb -> RUN.
REQ-022 I_btn pulse in RUN sets a pending flag; on the next fb in RUN, O_mode advances and the flag clears.
REQ-023 Advance rule: O_mode = (O_mode+1) wrapping NUM_MODES-1 -> 0; O_mode changes only on an fb cycle.
REQ-024 Auto: frame counter increments on each fb in RUN while I_auto=1; on fb with counter=FRAMES_PER_PATTERN-1, advance and clear the counter.
REQ-025 Pending btn and auto expiry on the same fb: single advance; counter and flag both clear.
REQ-026 I_auto=0: counter held at 0; manual advance clears the counter.
REQ-027 I_btn outside RUN is dropped; pending flag and counter clear on leaving RUN.
REQ-028 Resolution request changed again during DRAIN: the value sampled at the loading fb wins; a change during RESET/RESYNC is acted on after returning to RUN.

Reset
REQ-029 I_rst_n=0 sampled: state RUN, preset 0 timing on outputs, O_mode=0, O_tp_rst_n=0, O_busy=0, counter and pending flag 0, registered VS=1 (inactive at pol 0).
REQ-030 O_tp_rst_n returns to 1 the first cycle after I_rst_n=1 is sampled; reset mid-sequence aborts any state to the above values.

Configuration
REQ-031 Macro PATSEQ_AUTO_EN defined: auto-cycle (REQ-024..026) compiled in; undefined: I_auto ignored, no frame counter, advance only by I_btn.

Verification
REQ-032 Reset, I_res_sel=0, FRAMES_PER_PATTERN=3, I_auto=1 -> O_mode steps 0,1,2,3,0 every 3rd fb; O_busy=0 throughout.
REQ-033 I_auto=0, I_btn pulse mid-frame -> O_mode unchanged until the next fb, then +1; two pulses in one frame -> +1 only.
REQ-034 I_res_sel 0->2 -> O_busy=1; at next fb outputs become 1650/40/220/1280/750/5/20/720, pols 1; O_tp_rst_n low exactly 16 cycles; RUN after the first following fb.
REQ-035 FRAMES_PER_PATTERN=1, I_btn pulse before fb -> exactly one advance at that fb.
REQ-036 I_rst_n asserted during RESET state -> next cycle: preset 0 outputs, O_mode=0, O_busy=0, O_tp_rst_n=0.
REQ-037 Build without PATSEQ_AUTO_EN, I_auto=1, 200 frames, no I_btn -> O_mode stays 0.
